// File: rtl/uart_pkg.sv
// uart_pkg: register map, STATUS bit positions and
// FSM encodings shared by the UART peripheral files.
package uart_pkg;

  localparam logic REG_DATA   = 1'b0;
  localparam logic REG_STATUS = 1'b1;

  localparam int ST_TX_FULL   = 0;
  localparam int ST_TX_IDLE   = 1;
  localparam int ST_RX_VALID  = 2;
  localparam int ST_OVERRUN   = 3;
  localparam int ST_FRAME_ERR = 4;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO, first-word-fallthrough head.
// Ports: clk/rst, push+wdata, pop, head, full, empty.
module sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr;
  logic [DEPTH_LOG2:0] rd_ptr;
  logic                do_push;
  logic                do_pop;

  // Extra MSB tells a wrapped (full) pointer pair from empty.
  assign empty = (wr_ptr == rd_ptr);
  assign full  =
    (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
    (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);

  // Full checked on current state: a push into a full
  // FIFO is dropped even when a pop happens alongside.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  assign head = mem[rd_ptr[DEPTH_LOG2-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_periph.sv
// uart_periph: 8N1 UART on the 68000 bus, TX FIFO + RX holding reg.
// Ports: clk, rst, cs/rw/addr/din/dout bus, txd/rxd serial.
module uart_periph
  import uart_pkg::*;
#(
  parameter int CLK_DIV       = 217,
  parameter int TX_DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic        rw,
  input  logic        addr,
  input  logic [15:0] din,
  output logic [15:0] dout,
  output logic        txd,
  input  logic        rxd
);

  localparam logic [15:0] DIV_TC  = 16'(CLK_DIV - 1);
  localparam logic [15:0] HALF_TC = 16'(CLK_DIV / 2 - 1);

  // Bus access: one action per cs rising edge.
  logic cs_q;
  logic acc;
  logic wr_data;
  logic wr_stat;
  logic rd_data;
  logic rd_stat;
  logic unused_din;

  assign acc     = cs & ~cs_q;
  assign wr_data = acc & ~rw & (addr == REG_DATA);
  assign wr_stat = acc & ~rw & (addr == REG_STATUS);
  assign rd_data = acc & rw & (addr == REG_DATA);
  assign rd_stat = acc & rw & (addr == REG_STATUS);
  assign unused_din = ^din[15:8];

  always_ff @(posedge clk) begin
    if (rst) cs_q <= 1'b0;
    else     cs_q <= cs;
  end

  // TX FIFO
  logic [7:0] fifo_head;
  logic       fifo_pop;
  logic       fifo_full;
  logic       fifo_empty;

  sync_fifo #(
    .WIDTH      (8),
    .DEPTH_LOG2 (TX_DEPTH_LOG2)
  ) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_data),
    .wdata (din[7:0]),
    .pop   (fifo_pop),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // TX FSM
  tx_state_t   tx_state, tx_state_n;
  logic [15:0] tx_cnt, tx_cnt_n;
  logic [2:0]  tx_bit, tx_bit_n;
  logic [7:0]  tx_shift, tx_shift_n;
  logic        txd_n;
  logic        tx_term;

  assign tx_term = (tx_cnt == DIV_TC);

  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_bit_n   = tx_bit;
    tx_shift_n = tx_shift;
    fifo_pop   = 1'b0;
    if (tx_state != TX_IDLE)
      tx_cnt_n = tx_term ? '0 : tx_cnt + 16'd1;
    unique case (tx_state)
      TX_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          tx_shift_n = fifo_head;
          tx_cnt_n   = '0;
          tx_state_n = TX_START;
        end
      end
      TX_START: begin
        if (tx_term) begin
          tx_bit_n   = '0;
          tx_state_n = TX_DATA;
        end
      end
      TX_DATA: begin
        if (tx_term) begin
          tx_shift_n = {1'b1, tx_shift[7:1]};
          tx_bit_n   = tx_bit + 3'd1;
          if (tx_bit == 3'd7) tx_state_n = TX_STOP;
        end
      end
      TX_STOP: begin
        if (tx_term) begin
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            tx_shift_n = fifo_head;
            tx_state_n = TX_START;
          end else begin
            tx_state_n = TX_IDLE;
          end
        end
      end
    endcase
    // txd is registered from the next state to stay glitch-free.
    case (tx_state_n)
      TX_START: txd_n = 1'b0;
      TX_DATA:  txd_n = tx_shift_n[0];
      default:  txd_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      txd      <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      tx_shift <= tx_shift_n;
      txd      <= txd_n;
    end
  end

  // RX synchronizer plus a delayed copy for edge detect.
  logic rx_s1, rx_s2, rx_prev;
  logic rx_fall;

  assign rx_fall = rx_prev & ~rx_s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rxd;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // RX FSM
  rx_state_t   rx_state, rx_state_n;
  logic [15:0] rx_cnt, rx_cnt_n;
  logic [2:0]  rx_bit, rx_bit_n;
  logic [7:0]  rx_shift, rx_shift_n;
  logic        rx_done;

  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_bit_n   = rx_bit;
    rx_shift_n = rx_shift;
    rx_done    = 1'b0;
    if (rx_state != RX_IDLE) rx_cnt_n = rx_cnt + 16'd1;
    unique case (rx_state)
      RX_IDLE: begin
        if (rx_fall) begin
          rx_cnt_n   = '0;
          rx_state_n = RX_START;
        end
      end
      RX_START: begin
        // Mid start bit: a high line here was only a glitch.
        if (rx_cnt == HALF_TC) begin
          rx_cnt_n   = '0;
          rx_bit_n   = '0;
          rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt == DIV_TC) begin
          rx_cnt_n   = '0;
          rx_shift_n = {rx_s2, rx_shift[7:1]};
          rx_bit_n   = rx_bit + 3'd1;
          if (rx_bit == 3'd7) rx_state_n = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_cnt == DIV_TC) begin
          rx_cnt_n   = '0;
          rx_done    = 1'b1;
          rx_state_n = RX_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_bit   <= rx_bit_n;
      rx_shift <= rx_shift_n;
    end
  end

  // RX holding register and sticky flags
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       overrun;
  logic       frame_err;
  logic       rx_pop;
  logic       rx_ok;
  logic       rx_bad;

  assign rx_pop = rd_data & rx_valid;
  assign rx_ok  = rx_done & rx_s2;
  assign rx_bad = rx_done & ~rx_s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_byte   <= '0;
      rx_valid  <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      // A pop in the completion cycle frees the slot: no overrun.
      if (rx_ok) begin
        rx_byte  <= rx_shift;
        rx_valid <= 1'b1;
      end else if (rx_pop) begin
        rx_valid <= 1'b0;
      end
      if (rx_ok & rx_valid & ~rx_pop)
        overrun <= 1'b1;
      else if (wr_stat & din[ST_OVERRUN])
        overrun <= 1'b0;
      if (rx_bad)
        frame_err <= 1'b1;
      else if (wr_stat & din[ST_FRAME_ERR])
        frame_err <= 1'b0;
    end
  end

  // Read data
  logic [15:0] status;

  always_comb begin
    status               = '0;
    status[ST_TX_FULL]   = fifo_full;
    status[ST_TX_IDLE]   = fifo_empty & (tx_state == TX_IDLE);
    status[ST_RX_VALID]  = rx_valid;
    status[ST_OVERRUN]   = overrun;
    status[ST_FRAME_ERR] = frame_err;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout <= '0;
    end else begin
      unique case (1'b1)
        rd_data: dout <= {8'h00, rx_byte};
        rd_stat: dout <= status;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_periph.sv
// tb_uart_periph: directed self-checking bench for uart_periph.
// Runs with CLK_DIV=4; a txd monitor decodes frames.
module tb_uart_periph;

  localparam int BIT = 4;
  localparam logic [15:0] TXI = 16'h0002;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cs = 1'b0;
  logic        rw = 1'b0;
  logic        addr = 1'b0;
  logic [15:0] din = '0;
  logic [15:0] dout;
  logic        txd;
  logic        rxd = 1'b1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] mon_q[$];
  int         mon_t[$];

  uart_periph #(
    .CLK_DIV       (BIT),
    .TX_DEPTH_LOG2 (4)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .cs   (cs),
    .rw   (rw),
    .addr (addr),
    .din  (din),
    .dout (dout),
    .txd  (txd),
    .rxd  (rxd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input logic [15:0] got,
                       input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input logic a, input logic [15:0] d,
                        input int hold);
    @(posedge clk);
    #1 cs = 1'b1; rw = 1'b0; addr = a; din = d;
    repeat (hold) @(posedge clk);
    #1 cs = 1'b0;
  endtask

  task automatic bus_rd(input logic a, input int hold,
                        output logic [15:0] d);
    @(posedge clk);
    #1 cs = 1'b1; rw = 1'b1; addr = a;
    repeat (hold) @(posedge clk);
    #1 cs = 1'b0;
    @(negedge clk);
    d = dout;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stp);
    @(posedge clk);
    #1 rxd = 1'b0;
    repeat (BIT) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 rxd = b[i];
      repeat (BIT) @(posedge clk);
    end
    #1 rxd = stp;
    repeat (BIT) @(posedge clk);
    #1 rxd = 1'b1;
    repeat (BIT) @(posedge clk);
  endtask

  // txd frame decoder, sampling mid-bit
  initial begin
    logic [7:0] b;
    int t0;
    forever begin
      @(negedge clk);
      if (!rst && txd == 1'b0) begin
        t0 = cyc;
        repeat (BIT / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (BIT) @(negedge clk);
          b[i] = txd;
        end
        repeat (BIT) @(negedge clk);
        mon_q.push_back(b);
        mon_t.push_back(t0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] rd;
    logic [7:0]  v;
    logic        e;
    int          bad;

    // reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_txd", 16'(txd), 16'h0001);
    check("rst_dout", dout, 16'h0000);
    @(posedge clk);
    #1 rst = 1'b0;
    bus_rd(1'b1, 1, rd);
    check("rst_status", rd, TXI);

    // single TX byte, cycle-exact waveform
    mon_q.delete(); mon_t.delete();
    v = 8'h55;
    @(posedge clk);
    #1 cs = 1'b1; rw = 1'b0; addr = 1'b0; din = 16'h0055;
    @(posedge clk);
    #1 cs = 1'b0;
    @(negedge clk);
    check("tx_pre", 16'(txd), 16'h0001);
    for (int k = 0; k < 44; k++) begin
      @(negedge clk);
      if (k < 4)       e = 1'b0;
      else if (k < 36) e = v[(k - 4) / 4];
      else             e = 1'b1;
      if (txd !== e) begin
        $display("FAIL tx_wave k=%0d: got %b expected %b",
                 k, txd, e);
        errors++;
      end
      checks++;
    end
    bus_rd(1'b1, 1, rd);
    check("tx_idle", rd, TXI);
    check("tx_mon_cnt", 16'(mon_q.size()), 16'd1);
    if (mon_q.size() > 0) check("tx_mon_byte", 16'(mon_q[0]), 16'h0055);

    // FIFO full behind a busy frame
    mon_q.delete(); mon_t.delete();
    bus_wr(1'b0, 16'h00FF, 1);
    for (int i = 0; i < 17; i++) bus_wr(1'b0, 16'(i), 1);
    bus_rd(1'b1, 1, rd);
    check("fifo_full", rd, 16'h0001);
    for (int w = 0; w < 1200 && mon_q.size() < 17; w++)
      @(posedge clk);
    repeat (200) @(posedge clk);
    check("fifo_frames", 16'(mon_q.size()), 16'd17);
    for (int i = 0; i < mon_q.size(); i++)
      check($sformatf("fifo_byte%0d", i), 16'(mon_q[i]),
            (i == 0) ? 16'h00FF : 16'(i - 1));
    for (int i = 1; i < mon_t.size(); i++)
      check($sformatf("fifo_gap%0d", i),
            16'(mon_t[i] - mon_t[i-1]), 16'd40);

    // long cs write queues one byte
    mon_q.delete(); mon_t.delete();
    bus_wr(1'b0, 16'h00A5, 20);
    for (int w = 0; w < 300 && mon_q.size() < 1; w++)
      @(posedge clk);
    repeat (150) @(posedge clk);
    check("long_wr_cnt", 16'(mon_q.size()), 16'd1);
    if (mon_q.size() > 0) check("long_wr_byte", 16'(mon_q[0]), 16'h00A5);

    // RX byte
    send_rx(8'h3C, 1'b1);
    bus_rd(1'b1, 1, rd);
    check("rx_status", rd, 16'h0004 | TXI);
    bus_rd(1'b0, 1, rd);
    check("rx_data", rd, 16'h003C);
    bus_rd(1'b1, 1, rd);
    check("rx_popped", rd, 16'h0000 | TXI);

    // overrun, framing error, clear
    send_rx(8'h11, 1'b1);
    send_rx(8'h22, 1'b1);
    bus_rd(1'b1, 1, rd);
    check("ovr_status", rd, 16'h000C | TXI);
    send_rx(8'h77, 1'b0);
    bus_rd(1'b1, 1, rd);
    check("ferr_status", rd, 16'h001C | TXI);
    bus_rd(1'b0, 1, rd);
    check("ferr_data", rd, 16'h0022);
    bus_wr(1'b1, 16'h0018, 1);
    bus_rd(1'b1, 1, rd);
    check("clr_status", rd, 16'h0000 | TXI);

    // long cs read pops and holds dout
    send_rx(8'h5A, 1'b1);
    bus_rd(1'b0, 20, rd);
    check("long_rd_data", rd, 16'h005A);
    bus_rd(1'b1, 1, rd);
    check("long_rd_status", rd, TXI);
    repeat (10) @(negedge clk);
    check("dout_hold", dout, TXI);

    // RX completion coincident with a DATA-read pop
    send_rx(8'h81, 1'b1);
    fork
      send_rx(8'h42, 1'b1);
      begin
        repeat (40) @(posedge clk);
        bus_rd(1'b0, 1, rd);
      end
    join
    check("coinc_old", rd, 16'h0081);
    bus_rd(1'b1, 1, rd);
    check("coinc_status", rd, 16'h0004 | TXI);
    bus_rd(1'b0, 1, rd);
    check("coinc_new", rd, 16'h0042);

    // reset during data bit 3 with a second byte queued
    bus_wr(1'b0, 16'h0096, 1);
    bus_wr(1'b0, 16'h0069, 1);
    repeat (16) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("mid_bit3", 16'(txd), 16'h0000);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_txd_hi", 16'(txd), 16'h0001);
    check("rst_dout0", dout, 16'h0000);
    bus_rd(1'b1, 1, rd);
    check("rst_flush", rd, TXI);
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (txd !== 1'b1) bad++;
    end
    check("rst_quiet", 16'(bad), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
